// File: rtl/uart_tx_if.sv
// uart_tx_if: character handshake between transmit holding logic and the serializer
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    modport master (output data_in, data_valid, input data_ready);
    modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 16550-style serializer, start + 5..8 data LSB first + optional parity + 1/1.5/2 stop
module uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_tick,
    output logic       enable_sample,
    input  logic       enable,
    input  logic [3:0] data_bits,
    input  logic       stop_bits,
    input  logic       parity_en,
    input  logic       parity_even,
    input  logic       stick_parity,
    input  logic       break_ctrl,
    uart_tx_if.slave   dif,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);
    localparam int TW = $clog2(2 * OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [TW-1:0] tick_q, tick_d, stop_lim_q, lim;
    logic [2:0] bit_q, bit_d, last_q, last_c;
    logic [7:0] shreg_q, shreg_d, mask;
    logic line_q, line_d, busy_d, done_d, ready_q, ready_d, txd_q, txd_d;
    logic par_q, pen_q, par_c, load, step, adv;
    logic [TW-1:0] lim_c;
    assign last_c = data_bits < 4'd5 ? 3'd4 : data_bits > 4'd8 ? 3'd7 : 3'(data_bits - 4'd1);
    assign mask = 8'hFF >> (3'd7 - last_c);
    assign par_c = stick_parity ? ~parity_even : parity_even ? ^(dif.data_in & mask) : ~^(dif.data_in & mask);
    assign lim_c = !stop_bits ? TW'(OVERSAMPLE - 1) : last_c == 3'd4 ? TW'(OVERSAMPLE * 3 / 2 - 1) : TW'(2 * OVERSAMPLE - 1);
    assign step = sample_tick && busy;
    assign lim = state_q == STOP ? stop_lim_q : TW'(OVERSAMPLE - 1);
    assign adv = step && tick_q == lim;
    assign enable_sample = busy;
    assign dif.data_ready = ready_q;
    assign txd = txd_q;
    // next-state, tick/bit counting and next line value
    always_comb begin
        state_d = state_q;
        tick_d = step ? (adv ? '0 : tick_q + TW'(1)) : tick_q;
        bit_d = bit_q;
        shreg_d = shreg_q;
        line_d = line_q;
        busy_d = busy;
        done_d = 1'b0;
        ready_d = ready_q;
        load = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_d = enable;
                if (dif.data_valid && ready_q) begin
                    load = 1'b1;
                    state_d = START;
                    line_d = 1'b0;
                    busy_d = 1'b1;
                    ready_d = 1'b0;
                    tick_d = '0;
                    bit_d = '0;
                    shreg_d = dif.data_in;
                end
            end
            START: if (adv) begin
                state_d = DATA;
                line_d = shreg_q[0];
                shreg_d = shreg_q >> 1;
            end
            DATA: if (adv) begin
                if (bit_q == last_q) begin
                    state_d = pen_q ? PARITY : STOP;
                    line_d = pen_q ? par_q : 1'b1;
                end else begin
                    bit_d = bit_q + 3'd1;
                    line_d = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            PARITY: if (adv) begin
                state_d = STOP;
                line_d = 1'b1;
            end
            STOP: if (adv) begin
                state_d = IDLE;
                busy_d = 1'b0;
                done_d = 1'b1;
                ready_d = enable;
            end
            default: state_d = IDLE;
        endcase
        txd_d = break_ctrl ? 1'b0 : line_d;
    end
    // state, outputs and per-frame line format registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tick_q <= '0;
            bit_q <= '0;
            shreg_q <= '0;
            line_q <= 1'b1;
            txd_q <= 1'b1;
            busy <= 1'b0;
            tx_done <= 1'b0;
            ready_q <= 1'b0;
            last_q <= 3'd7;
            par_q <= 1'b0;
            pen_q <= 1'b0;
            stop_lim_q <= TW'(OVERSAMPLE - 1);
        end else begin
            state_q <= state_d;
            tick_q <= tick_d;
            bit_q <= bit_d;
            shreg_q <= shreg_d;
            line_q <= line_d;
            txd_q <= txd_d;
            busy <= busy_d;
            tx_done <= done_d;
            ready_q <= ready_d;
            if (load) begin
                last_q <= last_c;
                par_q <= par_c;
                pen_q <= parity_en;
                stop_lim_q <= lim_c;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, timing, handshake, reset and break
module tb_uart_tx;
    localparam int DIV = 3;
    logic clk = 1'b0, rst;
    logic sample_tick = 1'b0, enable_sample, enable;
    logic [3:0] data_bits;
    logic stop_bits, parity_en, parity_even, stick_parity, break_ctrl;
    logic txd, busy, tx_done;
    int div = 0, done_cnt = 0, n_vec = 0, n_bad = 0;
    uart_tx_if dif();
    uart_tx dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .enable_sample(enable_sample),
        .enable(enable), .data_bits(data_bits), .stop_bits(stop_bits), .parity_en(parity_en),
        .parity_even(parity_even), .stick_parity(stick_parity), .break_ctrl(break_ctrl),
        .dif(dif), .txd(txd), .busy(busy), .tx_done(tx_done)
    );
    always #5 clk = ~clk;
    // gated oversample tick generator: one tick every DIV clocks while requested
    always @(posedge clk) begin
        if (!enable_sample) begin
            div <= 0;
            sample_tick <= 1'b0;
        end else begin
            div <= (div == DIV - 1) ? 0 : div + 1;
            sample_tick <= (div == DIV - 1);
        end
    end
    // count tx_done pulses
    always @(negedge clk) if (tx_done) done_cnt++;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic sb, pe, pev, sp, scr);
        int t = 0;
        @(negedge clk);
        dif.data_in = d; data_bits = nb; stop_bits = sb;
        parity_en = pe; parity_even = pev; stick_parity = sp;
        dif.data_valid = 1'b1;
        while (!busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept", busy, 1);
        dif.data_valid = 1'b0;
        if (scr) begin
            dif.data_in = ~d; data_bits = 4'd5; stop_bits = ~sb;
            parity_en = ~pe; parity_even = ~pev; stick_parity = ~sp;
        end
    endtask
    task automatic frame(input string tag, input logic [11:0] bits, input int nb, input int total, input logic stopv);
        int k = 0, t = 0, d0 = done_cnt;
        while (k < total && t < 2000) begin
            @(negedge clk);
            t++;
            if (sample_tick) begin
                k++;
                if ((k - 1) % 16 == 8) begin
                    if ((k - 1) / 16 < nb) chk({tag, "_bit"}, txd, bits[(k - 1) / 16]);
                    else chk({tag, "_stop"}, txd, stopv);
                end
            end
        end
        chk({tag, "_ticks"}, k, total);
        chk({tag, "_early_done"}, done_cnt, d0);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, tx_done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ensample"}, enable_sample, 0);
        chk({tag, "_ready"}, dif.data_ready, 1);
    endtask
    initial begin
        int k, t, d0;
        rst = 1'b0; enable = 1'b0; break_ctrl = 1'b0;
        data_bits = 4'd8; stop_bits = 1'b0; parity_en = 1'b0; parity_even = 1'b0; stick_parity = 1'b0;
        dif.data_in = 8'h00; dif.data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_ready", dif.data_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ensample", enable_sample, 0);
        rst = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_follows_enable", dif.data_ready, 1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        dif.data_valid = 1'b1;
        dif.data_in = 8'h11;
        repeat (5) @(negedge clk);
        chk("disabled_busy", busy, 0);
        chk("disabled_ready", dif.data_ready, 0);
        dif.data_valid = 1'b0;
        enable = 1'b1;
        send(8'hA5, 4'd8, 0, 0, 0, 0, 1); frame("8N1", 12'h14A, 9, 160, 1);
        send(8'h3C, 4'd8, 0, 1, 1, 0, 1); frame("8E1", 12'h078, 10, 176, 1);
        send(8'h3C, 4'd8, 0, 1, 0, 0, 1); frame("8O1", 12'h278, 10, 176, 1);
        send(8'h07, 4'd8, 0, 1, 1, 1, 1); frame("stick", 12'h00E, 10, 176, 1);
        send(8'hFF, 4'd5, 1, 0, 0, 0, 1); frame("5N15", 12'h03E, 6, 120, 1);
        send(8'hE6, 4'd3, 1, 0, 0, 0, 0); frame("clamp_lo", 12'h00C, 6, 120, 1);
        send(8'h81, 4'd12, 1, 0, 0, 0, 0); frame("clamp_hi", 12'h102, 9, 176, 1);
        send(8'h55, 4'd8, 0, 0, 0, 0, 0);
        dif.data_valid = 1'b1;
        frame("b2b0", 12'h0AA, 9, 160, 1);
        @(posedge clk);
        #1;
        chk("b2b_gap0", busy, 1);
        frame("b2b1", 12'h0AA, 9, 160, 1);
        @(posedge clk);
        #1;
        chk("b2b_gap1", busy, 1);
        dif.data_valid = 1'b0;
        frame("b2b2", 12'h0AA, 9, 160, 1);
        repeat (3) @(negedge clk);
        chk("b2b_stop", busy, 0);
        send(8'hA5, 4'd8, 0, 0, 0, 0, 0);
        k = 0; t = 0;
        while (k < 72 && t < 2000) begin
            @(negedge clk);
            t++;
            if (sample_tick) k++;
        end
        chk("pre_rst_bit3", txd, 0);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        chk("abort_ensample", enable_sample, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        rst = 1'b1;
        send(8'hA5, 4'd8, 0, 0, 0, 0, 0); frame("after_rst", 12'h14A, 9, 160, 1);
        @(negedge clk);
        break_ctrl = 1'b1;
        send(8'hFF, 4'd8, 0, 0, 0, 0, 0); frame("break", 12'h000, 9, 160, 0);
        @(negedge clk);
        break_ctrl = 1'b0;
        @(posedge clk);
        #1;
        chk("break_release", txd, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
